// File: rtl/rex_draw_if.sv
// Valid/ready link from the draw sequencer to the rectangle fill engine,
// bundled with the game-state inputs that drive it.
interface rex_draw_if;
  logic        gpu_en;
  logic [15:0] dino_y;
  logic [15:0] obstacle_x;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;
  logic [15:0] cmd_w;
  logic [15:0] cmd_h;
  logic        cmd_color;
  logic        busy;
  logic        frame_done;

  modport master (
    input  gpu_en, dino_y, obstacle_x, cmd_ready,
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, busy, frame_done
  );

  modport slave (
    output gpu_en, dino_y, obstacle_x, cmd_ready,
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, busy, frame_done
  );
endinterface

// File: rtl/rex_draw_sequencer.sv
// Turns dino/obstacle positions into clear/erase/draw rectangle fill commands.
//
//   state      | meaning
//   IDLE       | waiting for enable and a pending change; snapshots inputs
//   CLEAR      | full-screen background fill (first enable / after abort)
//   ERASE_DINO | background fill over the previous dino position
//   DRAW_DINO  | foreground fill at the snapshot dino position
//   ERASE_OBS  | background fill over the previous obstacle position
//   DRAW_OBS   | foreground fill at the snapshot obstacle position
//   DONE       | one-cycle frame_done pulse
module rex_draw_sequencer #(
  parameter int SCREEN_W = 256,
  parameter int SCREEN_H = 64,
  parameter int GROUND_Y = 60,
  parameter int DINO_X   = 16,
  parameter int DINO_W   = 16,
  parameter int DINO_H   = 20,
  parameter int OBS_W    = 16,
  parameter int OBS_H    = 26
) (
  input  logic          clk,
  input  logic          rst,
  rex_draw_if.master    bus
);

  localparam logic [15:0] SW      = 16'(SCREEN_W);
  localparam logic [15:0] SH      = 16'(SCREEN_H);
  localparam logic [15:0] DX      = 16'(DINO_X);
  localparam logic [15:0] DW      = 16'(DINO_W);
  localparam logic [15:0] DH      = 16'(DINO_H);
  localparam logic [15:0] OW      = 16'(OBS_W);
  localparam logic [15:0] OH      = 16'(OBS_H);
  localparam logic [15:0] DINO_Y0 = 16'(GROUND_Y - DINO_H);
  localparam logic [15:0] OBS_Y   = 16'(GROUND_Y - OBS_H);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    ERASE_DINO = 3'd2,
    DRAW_DINO  = 3'd3,
    ERASE_OBS  = 3'd4,
    DRAW_OBS   = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t      state, state_n;
  logic [15:0] s_dy, s_ox;
  logic        clr_seq;
  logic [15:0] last_dino_y, last_obs_x;
  logic        need_clear;

  logic        cmd_valid;
  logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic        cmd_color;
  logic        xfer;
  logic        start;

  logic [15:0] f_dy, f_ox;
  logic        f_clr, dchg, ochg;
  logic [4:0]  app;

  // Obstacle width clipped at the right screen edge.
  function automatic logic [15:0] clip_w(input logic [15:0] x);
    logic [15:0] room;
    room = SW - x;
    return (room < OW) ? room : OW;
  endfunction

  // First applicable command stage at or after 'from'; DONE if none remain.
  function automatic state_t first_from(input logic [2:0] from, input logic [4:0] a);
    if (from <= 3'd0 && a[0]) return CLEAR;
    if (from <= 3'd1 && a[1]) return ERASE_DINO;
    if (from <= 3'd2 && a[2]) return DRAW_DINO;
    if (from <= 3'd3 && a[3]) return ERASE_OBS;
    if (from <= 3'd4 && a[4]) return DRAW_OBS;
    return DONE;
  endfunction

  // In IDLE the decision uses live inputs, afterwards the snapshot.
  always_comb begin
    f_dy  = (state == IDLE) ? bus.dino_y     : s_dy;
    f_ox  = (state == IDLE) ? bus.obstacle_x : s_ox;
    f_clr = (state == IDLE) ? need_clear     : clr_seq;
    dchg  = (f_dy != last_dino_y);
    ochg  = (f_ox != last_obs_x);
    app[0] = f_clr;
    app[1] = !f_clr && dchg;
    app[2] = f_clr || dchg;
    app[3] = !f_clr && ochg && (last_obs_x < SW);
    app[4] = (f_clr || ochg) && (f_ox < SW);
  end

  assign start = bus.gpu_en && (need_clear || dchg || ochg);
  assign xfer  = cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = first_from(3'd0, app);
      end
      CLEAR: begin
        cmd_valid = 1'b1;
        cmd_w     = SW;
        cmd_h     = SH;
        if (xfer) state_n = bus.gpu_en ? first_from(3'd1, app) : IDLE;
      end
      ERASE_DINO: begin
        cmd_valid = 1'b1;
        cmd_x     = DX;
        cmd_y     = DINO_Y0 - last_dino_y;
        cmd_w     = DW;
        cmd_h     = DH;
        if (xfer) state_n = bus.gpu_en ? first_from(3'd2, app) : IDLE;
      end
      DRAW_DINO: begin
        cmd_valid = 1'b1;
        cmd_x     = DX;
        cmd_y     = DINO_Y0 - s_dy;
        cmd_w     = DW;
        cmd_h     = DH;
        cmd_color = 1'b1;
        if (xfer) state_n = bus.gpu_en ? first_from(3'd3, app) : IDLE;
      end
      ERASE_OBS: begin
        cmd_valid = 1'b1;
        cmd_x     = last_obs_x;
        cmd_y     = OBS_Y;
        cmd_w     = clip_w(last_obs_x);
        cmd_h     = OH;
        if (xfer) state_n = bus.gpu_en ? first_from(3'd4, app) : IDLE;
      end
      DRAW_OBS: begin
        cmd_valid = 1'b1;
        cmd_x     = s_ox;
        cmd_y     = OBS_Y;
        cmd_w     = clip_w(s_ox);
        cmd_h     = OH;
        cmd_color = 1'b1;
        if (xfer) state_n = bus.gpu_en ? DONE : IDLE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_dy        <= '0;
      s_ox        <= '0;
      clr_seq     <= 1'b0;
      last_dino_y <= '0;
      last_obs_x  <= '0;
      need_clear  <= 1'b1;
    end else begin
      if (state == IDLE && start) begin
        s_dy    <= bus.dino_y;
        s_ox    <= bus.obstacle_x;
        clr_seq <= need_clear;
      end
      if (state == CLEAR && xfer)     need_clear  <= 1'b0;
      if (state == DRAW_DINO && xfer) last_dino_y <= s_dy;
      if (state == DRAW_OBS && xfer)  last_obs_x  <= s_ox;
      // Off-screen obstacles issue no draw but must still be remembered.
      if (state == DONE)              last_obs_x  <= s_ox;
      if (xfer && !bus.gpu_en)        need_clear  <= 1'b1;
    end
  end

  assign bus.cmd_valid  = cmd_valid;
  assign bus.cmd_x      = cmd_x;
  assign bus.cmd_y      = cmd_y;
  assign bus.cmd_w      = cmd_w;
  assign bus.cmd_h      = cmd_h;
  assign bus.cmd_color  = cmd_color;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == DONE);

endmodule

// File: tb/tb_rex_draw_sequencer.sv
// Directed bench for rex_draw_sequencer: hand-computed rectangle command sequences.
module tb_rex_draw_sequencer;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  rex_draw_if bus ();

  rex_draw_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Waits up to max_wait negedges for a command, checks it, then lets it transfer if ready.
  task automatic expect_cmd(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] w, input logic [15:0] h, input logic c,
                            input int max_wait);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_valid && n < max_wait - 1) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".valid"}, 32'(bus.cmd_valid), 32'd1);
    chk({tag, ".x"},     32'(bus.cmd_x),     32'(x));
    chk({tag, ".y"},     32'(bus.cmd_y),     32'(y));
    chk({tag, ".w"},     32'(bus.cmd_w),     32'(w));
    chk({tag, ".h"},     32'(bus.cmd_h),     32'(h));
    chk({tag, ".color"}, 32'(bus.cmd_color), 32'(c));
    if (bus.cmd_ready) @(posedge clk);
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'd1);
    chk({tag, ".no_extra"},   32'(bus.cmd_valid),  32'd0);
    @(negedge clk);
    chk({tag, ".idle"},       32'(bus.busy),       32'd0);
    chk({tag, ".pulse_end"},  32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    bus.gpu_en     = 1'b0;
    bus.dino_y     = 16'd0;
    bus.obstacle_x = 16'd232;
    bus.cmd_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.valid", 32'(bus.cmd_valid),  32'd0);
    chk("reset.busy",  32'(bus.busy),       32'd0);
    chk("reset.done",  32'(bus.frame_done), 32'd0);
    chk("reset.x",     32'(bus.cmd_x),      32'd0);
    rst = 1'b1;

    // gpu_en low: nothing happens.
    repeat (3) @(negedge clk);
    chk("disabled.valid", 32'(bus.cmd_valid), 32'd0);
    chk("disabled.busy",  32'(bus.busy),      32'd0);

    // T1: start-of-game clear and full draw, back to back.
    bus.gpu_en = 1'b1;
    expect_cmd("t1_clear", 16'd0,   16'd0,  16'd256, 16'd64, 1'b0, 4);
    expect_cmd("t1_dino",  16'd16,  16'd40, 16'd16,  16'd20, 1'b1, 1);
    expect_cmd("t1_obs",   16'd232, 16'd34, 16'd16,  16'd26, 1'b1, 1);
    expect_done("t1");

    // T2: obstacle moves only.
    bus.obstacle_x = 16'd224;
    expect_cmd("t2_erase", 16'd232, 16'd34, 16'd16, 16'd26, 1'b0, 4);
    expect_cmd("t2_draw",  16'd224, 16'd34, 16'd16, 16'd26, 1'b1, 1);
    expect_done("t2");

    // T3: dino jumps only.
    bus.dino_y = 16'd15;
    expect_cmd("t3_erase", 16'd16, 16'd40, 16'd16, 16'd20, 1'b0, 4);
    expect_cmd("t3_draw",  16'd16, 16'd25, 16'd16, 16'd20, 1'b1, 1);
    expect_done("t3");

    // T4: stall with a position change during the stall.
    bus.cmd_ready  = 1'b0;
    bus.obstacle_x = 16'd200;
    expect_cmd("t4_erase", 16'd224, 16'd34, 16'd16, 16'd26, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold.valid", 32'(bus.cmd_valid), 32'd1);
      chk("t4_hold.x",     32'(bus.cmd_x),     32'd224);
      chk("t4_hold.color", 32'(bus.cmd_color), 32'd0);
      if (i == 1) bus.obstacle_x = 16'd180;
    end
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    expect_cmd("t4_draw",   16'd200, 16'd34, 16'd16, 16'd26, 1'b1, 1);
    expect_done("t4");
    expect_cmd("t4_erase2", 16'd200, 16'd34, 16'd16, 16'd26, 1'b0, 4);
    expect_cmd("t4_draw2",  16'd180, 16'd34, 16'd16, 16'd26, 1'b1, 1);
    expect_done("t4b");

    // T5: clipping at the right edge and wrap-around.
    bus.obstacle_x = 16'd248;
    expect_cmd("t5_erase", 16'd180, 16'd34, 16'd16, 16'd26, 1'b0, 4);
    expect_cmd("t5_clip",  16'd248, 16'd34, 16'd8,  16'd26, 1'b1, 1);
    expect_done("t5");
    bus.obstacle_x = 16'd8;
    expect_cmd("t5_erase_clip", 16'd248, 16'd34, 16'd8,  16'd26, 1'b0, 4);
    expect_cmd("t5_draw8",      16'd8,   16'd34, 16'd16, 16'd26, 1'b1, 1);
    expect_done("t5b");
    bus.obstacle_x = 16'd240;
    expect_cmd("t5_erase8", 16'd8,   16'd34, 16'd16, 16'd26, 1'b0, 4);
    expect_cmd("t5_draw240", 16'd240, 16'd34, 16'd16, 16'd26, 1'b1, 1);
    expect_done("t5c");

    // T6: disable while a command is stalled.
    bus.cmd_ready  = 1'b0;
    bus.obstacle_x = 16'd100;
    expect_cmd("t6_stall", 16'd240, 16'd34, 16'd16, 16'd26, 1'b0, 4);
    bus.gpu_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_held.valid", 32'(bus.cmd_valid), 32'd1);
    chk("t6_held.x",     32'(bus.cmd_x),     32'd240);
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_quiet.valid", 32'(bus.cmd_valid),  32'd0);
      chk("t6_quiet.done",  32'(bus.frame_done), 32'd0);
    end
    chk("t6_quiet.busy", 32'(bus.busy), 32'd0);
    bus.gpu_en = 1'b1;
    expect_cmd("t6_clear", 16'd0,   16'd0,  16'd256, 16'd64, 1'b0, 4);
    expect_cmd("t6_dino",  16'd16,  16'd25, 16'd16,  16'd20, 1'b1, 1);
    expect_cmd("t6_obs",   16'd100, 16'd34, 16'd16,  16'd26, 1'b1, 1);
    expect_done("t6");

    // Async reset while a command is valid.
    bus.cmd_ready  = 1'b0;
    bus.obstacle_x = 16'd120;
    expect_cmd("rst_pre", 16'd100, 16'd34, 16'd16, 16'd26, 1'b0, 4);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async.valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_async.busy",  32'(bus.busy),      32'd0);
    chk("rst_async.x",     32'(bus.cmd_x),     32'd0);
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    rst = 1'b1;
    expect_cmd("rst_clear", 16'd0,   16'd0,  16'd256, 16'd64, 1'b0, 4);
    expect_cmd("rst_dino",  16'd16,  16'd25, 16'd16,  16'd20, 1'b1, 1);
    expect_cmd("rst_obs",   16'd120, 16'd34, 16'd16,  16'd26, 1'b1, 1);
    expect_done("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
